// File: rtl/conv_pool_engine.sv
// rtl/conv_pool_engine.sv - 3x3 convolution with bias/ReLU/saturation into layer 0, then 2x2 max-pool into layer 1
module conv_pool_engine #(
  parameter int XW      = 6,
  parameter int YW      = 6,
  parameter int DW      = 20,
  parameter int FRAC    = 16,
  parameter int POOL_EN = 1,
  parameter int RELU_EN = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ready,
  output logic                 o_busy,
  input  logic                 i_k_we,
  input  logic [3:0]           i_k_idx,
  input  logic [DW-1:0]        i_k_data,
  output logic [XW+YW-1:0]     o_iaddr,
  input  logic [DW-1:0]        i_idata,
  output logic                 o_crd,
  output logic [XW+YW-1:0]     o_caddr_rd,
  input  logic [DW-1:0]        i_cdata_rd,
  output logic                 o_cwr,
  output logic [XW+YW-1:0]     o_caddr_wr,
  output logic [DW-1:0]        o_cdata_wr,
  output logic [2:0]           o_csel
);

  localparam int AccW = 2*DW + 4;
  localparam logic signed [AccW-1:0] SatHi = {{(AccW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AccW-1:0] SatLo = {{(AccW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_CONV_RD, S_CONV_ACC, S_CONV_WR, S_POOL_RD, S_POOL_CMP, S_POOL_WR, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [XW-1:0]            r_x;
  logic [YW-1:0]            r_y;
  logic [3:0]               r_tap;
  logic [XW-2:0]            r_px;
  logic [YW-2:0]            r_py;
  logic [1:0]               r_pt;
  logic signed [DW-1:0]     r_w [9];
  logic signed [DW-1:0]     r_bias;
  logic signed [AccW-1:0]   r_acc;
  logic                     r_pv;
  logic [3:0]               r_pidx;
  logic                     r_rv;
  logic                     r_rfirst;
  logic signed [DW-1:0]     r_max;

  logic                     w_last_pix, w_last_pool;
  logic [1:0]               w_row, w_col;
  logic [YW-1:0]            w_ty;
  logic [XW-1:0]            w_tx;
  logic                     w_in_img;
  logic signed [2*DW-1:0]   w_prod;
  logic signed [AccW-1:0]   w_sum, w_shr, w_relu;
  logic [DW-1:0]            w_res;

  assign w_last_pix  = (&r_x) && (&r_y);
  assign w_last_pool = (&r_px) && (&r_py);

  // Tap t maps to kernel row t/3 and column t%3; offsets are row-1, col-1.
  always_comb begin
    w_row    = (r_tap >= 4'd6) ? 2'd2 : (r_tap >= 4'd3) ? 2'd1 : 2'd0;
    w_col    = 2'(r_tap - {2'b00, w_row} * 4'd3);
    w_ty     = r_y + YW'(w_row) - YW'(1'b1);
    w_tx     = r_x + XW'(w_col) - XW'(1'b1);
    w_in_img = !((w_row == 2'd0) && (r_y == '0)) && !((w_row == 2'd2) && (&r_y)) &&
               !((w_col == 2'd0) && (r_x == '0)) && !((w_col == 2'd2) && (&r_x));
  end

  assign w_prod = r_w[r_pidx] * $signed(i_idata);

  always_comb begin
    w_sum  = r_acc + ({{(AccW-DW){r_bias[DW-1]}}, r_bias} << FRAC) + (AccW'(1) << (FRAC-1));
    w_shr  = w_sum >>> FRAC;
    w_relu = ((RELU_EN != 0) && w_shr[AccW-1]) ? '0 : w_shr;
    if (w_relu > SatHi)
      w_res = SatHi[DW-1:0];
    else if (w_relu < SatLo)
      w_res = SatLo[DW-1:0];
    else
      w_res = w_relu[DW-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (i_ready) w_next = S_CONV_RD;
      S_CONV_RD:  if (r_tap == 4'd8) w_next = S_CONV_ACC;
      S_CONV_ACC: w_next = S_CONV_WR;
      S_CONV_WR:  if (w_last_pix) w_next = (POOL_EN != 0) ? S_POOL_RD : S_DONE;
                  else            w_next = S_CONV_RD;
      S_POOL_RD:  if (r_pt == 2'd3) w_next = S_POOL_CMP;
      S_POOL_CMP: w_next = S_POOL_WR;
      S_POOL_WR:  w_next = w_last_pool ? S_DONE : S_POOL_RD;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (r_state != S_IDLE);
    o_iaddr    = '0;
    o_crd      = 1'b0;
    o_caddr_rd = '0;
    o_cwr      = 1'b0;
    o_caddr_wr = '0;
    o_cdata_wr = '0;
    o_csel     = 3'b000;
    case (r_state)
      S_CONV_RD: o_iaddr = {w_ty, w_tx};
      S_CONV_WR: begin
        o_cwr      = 1'b1;
        o_csel     = 3'b001;
        o_caddr_wr = {r_y, r_x};
        o_cdata_wr = w_res;
      end
      S_POOL_RD: begin
        o_crd      = 1'b1;
        o_csel     = 3'b001;
        o_caddr_rd = {r_py, r_pt[1], r_px, r_pt[0]};
      end
      S_POOL_WR: begin
        o_cwr      = 1'b1;
        o_csel     = 3'b011;
        o_caddr_wr = {2'b00, r_py, r_px};
        o_cdata_wr = r_max;
      end
      default: ;
    endcase
  end

  // Products land one cycle after their tap address; out-of-image taps never reach the accumulator.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_x      <= '0;
      r_y      <= '0;
      r_tap    <= '0;
      r_px     <= '0;
      r_py     <= '0;
      r_pt     <= '0;
      r_bias   <= '0;
      r_acc    <= '0;
      r_pv     <= 1'b0;
      r_pidx   <= '0;
      r_rv     <= 1'b0;
      r_rfirst <= 1'b0;
      r_max    <= '0;
      for (int i = 0; i < 9; i++) r_w[i] <= '0;
    end else begin
      r_pv     <= (r_state == S_CONV_RD) && w_in_img;
      r_pidx   <= r_tap;
      r_rv     <= (r_state == S_POOL_RD);
      r_rfirst <= (r_pt == 2'd0);

      if (r_state == S_CONV_WR)
        r_acc <= '0;
      else if (r_pv)
        r_acc <= r_acc + {{(AccW-2*DW){w_prod[2*DW-1]}}, w_prod};

      if (r_rv && (r_rfirst || ($signed(i_cdata_rd) > r_max)))
        r_max <= i_cdata_rd;

      case (r_state)
        S_IDLE: begin
          if (i_k_we) begin
            for (int i = 0; i < 9; i++)
              if (i_k_idx == 4'(i)) r_w[i] <= i_k_data;
            if (i_k_idx == 4'd9) r_bias <= i_k_data;
          end
          if (i_ready) begin
            r_x   <= '0;
            r_y   <= '0;
            r_tap <= '0;
            r_px  <= '0;
            r_py  <= '0;
            r_pt  <= '0;
            r_acc <= '0;
          end
        end
        S_CONV_RD: r_tap <= (r_tap == 4'd8) ? 4'd0 : r_tap + 4'd1;
        S_CONV_WR: begin
          r_x <= r_x + 1'b1;
          if (&r_x) r_y <= r_y + 1'b1;
        end
        S_POOL_RD: r_pt <= r_pt + 2'd1;
        S_POOL_WR: begin
          r_px <= r_px + 1'b1;
          if (&r_px) r_py <= r_py + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
